vec_serializer: RTL and testbench



---
 rtl/vec_serializer.sv | 158 +++++++++++++++
 tb/tb_vec_serializer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_serializer.sv
// ---------------------------------------------------------------------------
// vec_serializer
//   Takes a WIDTH-bit word over a valid/ready handshake and streams it out one
//   bit per accepted beat, LSB first. Each beat is tagged with its group
//   (position / GROUP) and its index inside that group (position % GROUP),
//   together with a running count of the ones emitted so far in this word.
//   A per-word invert flag, captured with the word, complements every
//   emitted bit.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous reset, active-high
//   in_valid   : input word available
//   in_ready   : block can accept a word (high only while idle)
//   in_data    : word to serialize; bit 0 goes out first
//   in_invert  : captured with in_data; 1 = emit complemented bits
//   out_valid  : out_bit and its tags are valid
//   out_ready  : downstream accepts the current beat
//   out_bit    : current bit after optional inversion
//   out_group  : current bit position / GROUP
//   out_index  : current bit position % GROUP
//   out_last   : current beat is bit position WIDTH-1
//   ones_count : ones emitted in this word up to and including this beat
// ---------------------------------------------------------------------------
module vec_serializer #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8,
  localparam int NG = WIDTH / GROUP,
  localparam int GW = $clog2(NG),
  localparam int IW = $clog2(GROUP),
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_invert,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [GW-1:0]    out_group,
  output logic [IW-1:0]    out_index,
  output logic             out_last,
  output logic [CW-1:0]    ones_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             inv_q, inv_d;
  logic [GW-1:0]    group_q, group_d;
  logic [IW-1:0]    index_q, index_d;
  logic [CW-1:0]    acc_q, acc_d;

  logic             bit_s;
  logic             last_s;
  logic             index_wrap_s;

  // Beat decode: current bit, last-position and group-wrap flags from registered state.
  always_comb begin
    index_wrap_s = (index_q == IW'(GROUP - 1));
    if (state_q == SHIFT) begin
      bit_s  = shreg_q[0] ^ inv_q;
      last_s = (group_q == GW'(NG - 1)) && index_wrap_s;
    end else begin
      bit_s  = 1'b0;
      last_s = 1'b0;
    end
  end

  // Next-state logic: load in IDLE, advance position and accumulator per accepted beat.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    inv_d   = inv_q;
    group_d = group_q;
    index_d = index_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          inv_d   = in_invert;
          group_d = {GW{1'b0}};
          index_d = {IW{1'b0}};
          acc_d   = {CW{1'b0}};
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          acc_d   = acc_q + CW'(bit_s);
          if (last_s) begin
            // Word finished: counters return to zero so IDLE shows all-zero tags.
            state_d = IDLE;
            group_d = {GW{1'b0}};
            index_d = {IW{1'b0}};
            acc_d   = {CW{1'b0}};
          end else if (index_wrap_s) begin
            index_d = {IW{1'b0}};
            group_d = group_q + GW'(1);
          end else begin
            index_d = index_q + IW'(1);
          end
        end else begin
          // Backpressure: everything holds.
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= {WIDTH{1'b0}};
      inv_q   <= 1'b0;
      group_q <= {GW{1'b0}};
      index_q <= {IW{1'b0}};
      acc_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      inv_q   <= inv_d;
      group_q <= group_d;
      index_q <= index_d;
      acc_q   <= acc_d;
    end
  end

  // Output mapping: tags straight from registers, bit/last/count gated to zero in IDLE.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == SHIFT);
    out_bit   = bit_s;
    out_group = group_q;
    out_index = index_q;
    out_last  = last_s;
    if (state_q == SHIFT) begin
      ones_count = acc_q + CW'(bit_s);
    end else begin
      ones_count = {CW{1'b0}};
    end
  end

endmodule

// File: tb/tb_vec_serializer.sv
// ---------------------------------------------------------------------------
// tb_vec_serializer
//   Scoreboard bench for vec_serializer at WIDTH=32, GROUP=8. Loading a word
//   pushes its 32 expected beats into a queue; an independent monitor pops
//   and compares on every accepted beat. Directed checks cover reset, idle
//   outputs, backpressure hold, ignored loads during SHIFT and mid-word reset.
// ---------------------------------------------------------------------------
module tb_vec_serializer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_invert;
  logic        out_valid;
  logic        out_ready;
  logic        out_bit;
  logic [1:0]  out_group;
  logic [2:0]  out_index;
  logic        out_last;
  logic [5:0]  ones_count;

  typedef struct packed {
    logic       b;
    logic [1:0] g;
    logic [2:0] i;
    logic       l;
    logic [5:0] c;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec;
  int    n_err;
  int    beat_no;
  int    shift_cycles;
  logic  chk_after_last;
  logic [5:0] last_ones;

  vec_serializer #(.WIDTH(32), .GROUP(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_invert  (in_invert),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bit    (out_bit),
    .out_group  (out_group),
    .out_index  (out_index),
    .out_last   (out_last),
    .ones_count (ones_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected beat stream for one word: bit k (optionally inverted), tags, running count.
  task automatic push_word(input logic [31:0] d, input logic inv);
    int    ones;
    beat_t e;
    ones = 0;
    for (int k = 0; k < 32; k++) begin
      e.b = d[k] ^ inv;
      ones += int'(e.b);
      e.g = 2'(k / 8);
      e.i = 3'(k % 8);
      e.l = (k == 31);
      e.c = 6'(ones);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compare every accepted beat with the scoreboard head.
  always @(negedge clk) begin
    beat_t e;
    beat_t a;
    if (!rst) begin
      if (chk_after_last) begin
        n_vec++;
        if (!(in_ready === 1'b1 && out_valid === 1'b0)) begin
          n_err++;
          $display("FAIL ready_after_last: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        chk_after_last = 1'b0;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        a = {out_bit, out_group, out_index, out_last, ones_count};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got bit=%b g=%0d i=%0d last=%b ones=%0d with empty scoreboard",
                   out_bit, out_group, out_index, out_last, ones_count);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_err++;
            $display("FAIL beat%0d: got bit=%b g=%0d i=%0d last=%b ones=%0d, required bit=%b g=%0d i=%0d last=%b ones=%0d",
                     beat_no, a.b, a.g, a.i, a.l, a.c, e.b, e.g, e.i, e.l, e.c);
          end
          if (e.l) begin
            chk_after_last = 1'b1;
            last_ones      = a.c;
            beat_no        = 0;
          end else begin
            beat_no++;
          end
        end
      end
    end
  end

  // Counts cycles spent presenting beats, for the backpressure timing check.
  always @(negedge clk) begin
    if (out_valid === 1'b1) shift_cycles++;
  end

  task automatic check_idle(input string name);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bit !== 1'b0 || out_group !== 2'd0 ||
        out_index !== 3'd0 || out_last !== 1'b0 || ones_count !== 6'd0) begin
      n_err++;
      $display("FAIL %s: valid=%b ready=%b bit=%b g=%0d i=%0d last=%b ones=%0d, required 0/1 and all zero",
               name, out_valid, in_ready, out_bit, out_group, out_index, out_last, ones_count);
    end
  endtask

  task automatic check_val(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Wait (bounded) until the scoreboard is drained and the DUT is idle; returns at a negedge.
  task automatic wait_idle(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!(in_ready === 1'b1 && exp_q.size() == 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: in_ready=%b pending=%0d after %0d cycles, required idle", name, in_ready, exp_q.size(), t);
      exp_q.delete();
    end
  endtask

  // Load one word; must be called at a negedge with in_ready high. Returns just after the load edge.
  task automatic load(input logic [31:0] d, input logic inv);
    push_word(d, inv);
    in_data   = d;
    in_invert = inv;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    beat_no        = 0;
    shift_cycles   = 0;
    chk_after_last = 1'b0;
    last_ones      = 6'd0;
    out_ready      = 1'b1;
    // Reset held together with a load request: reset must win.
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hFFFF_FFFF;
    in_invert = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_idle("reset_state");

    // Alternating word, plain and inverted.
    load(32'hAAAA_AAAA, 1'b0);
    wait_idle("alt");
    check_val("alt_final_ones", int'(last_ones), 16);
    load(32'hAAAA_AAAA, 1'b1);
    wait_idle("alt_inv");
    check_val("alt_inv_final_ones", int'(last_ones), 16);

    // All ones, and all zeros inverted: count reaches 32 without wrapping.
    load(32'hFFFF_FFFF, 1'b0);
    wait_idle("ones");
    check_val("ones_final", int'(last_ones), 32);
    load(32'h0000_0000, 1'b1);
    wait_idle("zeros_inv");
    check_val("zeros_inv_final", int'(last_ones), 32);
    check_idle("idle_between_words");

    // Backpressure at beat 12 for 5 cycles. 0xA5A55A5A: bit12=1, ones in bits 0..12 = 7.
    shift_cycles = 0;
    load(32'hA5A5_5A5A, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("bp_valid", int'(out_valid), 1);
      check_val("bp_group", int'(out_group), 1);
      check_val("bp_index", int'(out_index), 4);
      check_val("bp_bit", int'(out_bit), 1);
      check_val("bp_ones", int'(ones_count), 7);
      @(posedge clk);
    end
    #1;
    out_ready = 1'b1;
    wait_idle("bp");
    check_val("bp_shift_cycles", shift_cycles, 37);

    // A second word offered during SHIFT must wait for the first to finish.
    load(32'h1234_5678, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    in_data   = 32'h0F0F_00FF;
    in_invert = 1'b0;
    in_valid  = 1'b1;
    push_word(32'h0F0F_00FF, 1'b0);
    @(negedge clk);
    check_val("busy_in_ready", int'(in_ready), 0);
    begin
      int t;
      t = 0;
      while (in_ready !== 1'b1 && t < 100) begin
        @(negedge clk);
        t++;
      end
      check_val("busy_wait_bounded", int'(t < 100), 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle("second_word");

    // Reset while beat 20 is presented: word discarded, idle next cycle.
    load(32'hDEAD_BEEF, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_pending_beats", exp_q.size(), 12);
    exp_q.delete();
    beat_no = 0;
    @(negedge clk);
    check_idle("rst_mid_word");
    load(32'h0000_0003, 1'b0);
    wait_idle("after_rst");
    check_val("after_rst_final_ones", int'(last_ones), 2);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
